// File: rtl/line_doubler.sv
// -----------------------------------------------------------------------------
// line_doubler
//
// Scan doubler placed directly after the palette stage. Each 15 kHz source
// line of 8-bit RGB (R3 G3 B2) is captured into one half of a ping-pong line
// buffer while the other half, holding the line completed last, is replayed
// twice at double pixel rate. Sync and data-enable are regenerated for a
// 31 kHz VGA timing. The output drives the board DAC / HDMI encoder.
//
// Ports
//   clk          system clock
//   rst_n        synchronous active-low reset
//   pix_en       source pixel strobe (palette outputs valid this cycle)
//   out_en       output pixel strobe, twice the pix_en rate
//   video_valid  source pixel is active (not blanked)
//   r_sig        source red   (3 bits)
//   g_sig        source green (3 bits)
//   b_sig        source blue  (2 bits)
//   src_hsync_n  source hsync, active low; its falling edge starts a line
//   src_vsync_n  source vsync, active low; latched at each line start
//   vga_r        output red   (3 bits)
//   vga_g        output green (3 bits)
//   vga_b        output blue  (2 bits)
//   vga_hs_n     output hsync, active low
//   vga_vs_n     output vsync, active low
//   vga_de       output active-video enable
//
// All outputs have a fixed two-clock latency from the edge at which the
// output pixel counter takes the corresponding value.
// -----------------------------------------------------------------------------
module line_doubler #(
   parameter int H_ACTIVE    = 256,  // stored pixels per line
   parameter int SRC_H_TOTAL = 384,  // output pixels per output line
   parameter int H_START     = 64,   // first active output pixel
   parameter int HS_START    = 320,  // output pixel where vga_hs_n falls
   parameter int HS_WIDTH    = 32    // vga_hs_n low width in output pixels
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pix_en,
   input  logic       out_en,
   input  logic       video_valid,
   input  logic [2:0] r_sig,
   input  logic [2:0] g_sig,
   input  logic [1:0] b_sig,
   input  logic       src_hsync_n,
   input  logic       src_vsync_n,
   output logic [2:0] vga_r,
   output logic [2:0] vga_g,
   output logic [1:0] vga_b,
   output logic       vga_hs_n,
   output logic       vga_vs_n,
   output logic       vga_de
);

   // ---------------------------------------------------------------------------
   // Widths and sized timing constants
   // ---------------------------------------------------------------------------
   localparam int AW = $clog2(H_ACTIVE);       // line buffer address per bank
   localparam int PW = $clog2(H_ACTIVE + 1);   // write pointer, saturates at H_ACTIVE
   localparam int HW = $clog2(SRC_H_TOTAL);    // output pixel counter

   localparam logic [PW-1:0] WR_LIMIT  = PW'(H_ACTIVE);
   localparam logic [HW-1:0] H_LAST    = HW'(SRC_H_TOTAL - 1);
   localparam logic [HW-1:0] ACT_FIRST = HW'(H_START);
   localparam logic [HW-1:0] ACT_END   = HW'(H_START + H_ACTIVE);
   localparam logic [HW-1:0] HS_FIRST  = HW'(HS_START);
   localparam logic [HW-1:0] HS_END    = HW'(HS_START + HS_WIDTH);
   localparam logic [AW-1:0] ADDR_OFS  = AW'(H_START);

   typedef struct packed {
      logic [2:0] r;
      logic [2:0] g;
      logic [1:0] b;
   } pixel_t;

   // ---------------------------------------------------------------------------
   // Signals
   // ---------------------------------------------------------------------------
   logic          hs_prev;
   logic          line_start;

   logic          wr_bank;
   logic [PW-1:0] wr_ptr;
   logic          wr_en;
   pixel_t        wr_data;

   logic          seen_start;
   logic          primed;
   logic          vs_latched;

   logic [HW-1:0] hcnt;
   logic [HW-1:0] hcnt_next;
   logic          active;
   logic          hs_window;
   logic [AW-1:0] rd_addr;

   // Two banks of H_ACTIVE pixels, bank select is the address MSB.
   pixel_t        mem [2**(AW+1)];
   pixel_t        rd_data;

   logic          act_d1;
   logic          hs_d1;
   logic          vs_d1;

   // ---------------------------------------------------------------------------
   // Line start: falling edge of src_hsync_n against its registered copy.
   // Evaluated every clk, independent of the pixel strobes.
   // ---------------------------------------------------------------------------
   assign line_start = hs_prev & ~src_hsync_n;

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hs_prev    <= 1'b0;
         wr_bank    <= 1'b0;
         seen_start <= 1'b0;
         primed     <= 1'b0;
         vs_latched <= 1'b1;
      end else begin
         hs_prev <= src_hsync_n;
         if (line_start) begin
            wr_bank    <= ~wr_bank;
            vs_latched <= src_vsync_n;
            seen_start <= 1'b1;
            // The second line start after reset means the read bank holds
            // a complete line.
            if (seen_start) begin
               primed <= 1'b1;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Write side: one entry per pix_en until the line is full, then hold.
   // Blanked pixels store black so short lines cannot leak old content
   // into the active window on the next capture of this bank.
   // ---------------------------------------------------------------------------
   assign wr_en   = rst_n & pix_en & (wr_ptr < WR_LIMIT);
   assign wr_data = video_valid ? pixel_t'{r: r_sig, g: g_sig, b: b_sig} : pixel_t'('0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
      end else if (line_start) begin
         wr_ptr <= '0;
      end else if (wr_en) begin
         wr_ptr <= wr_ptr + PW'(1);
      end
   end

   // ---------------------------------------------------------------------------
   // Output pixel counter. Line start wins over the out_en increment so the
   // replay re-locks to the source even when both arrive together. Without
   // source hsync the counter simply keeps wrapping over the same bank.
   // ---------------------------------------------------------------------------
   // NOTE: every combinational output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      hcnt_next = hcnt;
      if (line_start) begin
         hcnt_next = '0;
      end else if (out_en) begin
         hcnt_next = (hcnt == H_LAST) ? '0 : hcnt + HW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hcnt <= '0;
      end else begin
         hcnt <= hcnt_next;
      end
   end

   // ---------------------------------------------------------------------------
   // Read-side decode, valid for the current hcnt value.
   // The read address only needs the low bits: (hcnt - H_START) mod 2**AW.
   // ---------------------------------------------------------------------------
   assign active    = primed && (hcnt >= ACT_FIRST) && (hcnt < ACT_END);
   assign hs_window = (hcnt >= HS_FIRST) && (hcnt < HS_END);
   assign rd_addr   = hcnt[AW-1:0] - ADDR_OFS;

   // ---------------------------------------------------------------------------
   // Line buffer: true dual-port, synchronous read. The read bank is always
   // the opposite of the write bank, so same-address collisions cannot occur.
   // ---------------------------------------------------------------------------
   // NOTE: the buffer has no reset; its contents are never visible before a
   // full line has been written because the output is gated by primed.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[{wr_bank, wr_ptr[AW-1:0]}] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      rd_data <= mem[{~wr_bank, rd_addr}];
   end

   // ---------------------------------------------------------------------------
   // Output pipeline. Stage 1 runs alongside the RAM read so the controls stay
   // aligned with rd_data; stage 2 registers the pins and blanks colour
   // outside the active window.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         act_d1   <= 1'b0;
         hs_d1    <= 1'b0;
         vs_d1    <= 1'b1;
         vga_r    <= '0;
         vga_g    <= '0;
         vga_b    <= '0;
         vga_de   <= 1'b0;
         vga_hs_n <= 1'b1;
         vga_vs_n <= 1'b1;
      end else begin
         act_d1   <= active;
         hs_d1    <= hs_window;
         vs_d1    <= vs_latched;
         vga_r    <= act_d1 ? rd_data.r : '0;
         vga_g    <= act_d1 ? rd_data.g : '0;
         vga_b    <= act_d1 ? rd_data.b : '0;
         vga_de   <= act_d1;
         vga_hs_n <= ~hs_d1;
         vga_vs_n <= vs_d1;
      end
   end

endmodule

// File: tb/tb_line_doubler.sv
// -----------------------------------------------------------------------------
// tb_line_doubler
//
// Directed bench for line_doubler. Strobes follow a fixed line-relative
// schedule: out_en on even cycles, pix_en every fourth cycle, source hsync
// falling at cycle 2 of each line. With a 1536-cycle source line, output
// pixel h of replay r is first visible at line cycle 4 + 2*h + 768*r and
// held for two cycles. Every output is captured per line cycle and compared
// with values computed here from the stimulus.
// -----------------------------------------------------------------------------
module tb_line_doubler;

   localparam int LINE = 1536;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pix_en;
   logic       out_en;
   logic       video_valid;
   logic [2:0] r_sig;
   logic [2:0] g_sig;
   logic [1:0] b_sig;
   logic       src_hsync_n;
   logic       src_vsync_n;
   logic [2:0] vga_r;
   logic [2:0] vga_g;
   logic [1:0] vga_b;
   logic       vga_hs_n;
   logic       vga_vs_n;
   logic       vga_de;

   int checks = 0;
   int errors = 0;

   // Per-line capture, indexed by line cycle.
   logic       de_s  [LINE];
   logic [7:0] rgb_s [LINE];
   logic       hs_s  [LINE];
   logic       vs_s  [LINE];

   // First mismatch found by scan_bad.
   int         bad_c;
   logic [7:0] bad_act;
   logic [7:0] bad_exp;

   always #5 clk = ~clk;

   line_doubler dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pix_en      (pix_en),
      .out_en      (out_en),
      .video_valid (video_valid),
      .r_sig       (r_sig),
      .g_sig       (g_sig),
      .b_sig       (b_sig),
      .src_hsync_n (src_hsync_n),
      .src_vsync_n (src_vsync_n),
      .vga_r       (vga_r),
      .vga_g       (vga_g),
      .vga_b       (vga_b),
      .vga_hs_n    (vga_hs_n),
      .vga_vs_n    (vga_vs_n),
      .vga_de      (vga_de)
   );

   // Stored pixel value for source pixel k under each stimulus mode:
   // 0 = ramp k, 1 = ramp with pixels 100..109 blanked, 2 = inverted ramp.
   function automatic logic [7:0] exp_pix(input int mode, input int k);
      logic [7:0] kb;
      kb = k[7:0];
      if (mode == 1 && k >= 100 && k <= 109) return 8'h00;
      if (mode == 2) return ~kb;
      return kb;
   endfunction

   // Compares the captured line against the expected replay of a line written
   // in 'mode'. what: 0 = rgb, 1 = de, 2 = hs_n. Returns mismatch count.
   function automatic int scan_bad(input int what, input int mode, input bit primed);
      int         n;
      int         c;
      bit         act;
      logic [7:0] e;
      logic [7:0] a;
      n     = 0;
      bad_c = -1;
      for (int r = 0; r < 2; r++) begin
         for (int h = 0; h < 384; h++) begin
            c   = 4 + 2 * h + 768 * r;
            act = primed && (h >= 64) && (h < 320);
            case (what)
               0:       e = act ? exp_pix(mode, h - 64) : 8'h00;
               1:       e = {7'd0, act};
               default: e = {7'd0, !(h >= 320 && h < 352)};
            endcase
            for (int d = 0; d < 2; d++) begin
               if (c + d < LINE) begin
                  case (what)
                     0:       a = rgb_s[c + d];
                     1:       a = {7'd0, de_s[c + d]};
                     default: a = {7'd0, hs_s[c + d]};
                  endcase
                  if (a !== e) begin
                     n++;
                     if (bad_c < 0) begin
                        bad_c   = c + d;
                        bad_act = a;
                        bad_exp = e;
                     end
                  end
               end
            end
         end
      end
      return n;
   endfunction

   // Counts captured cycles in [lo, hi] where: 0 rgb != 0, 1 de high,
   // 2 hs_n low, 3 vs_n low, 4 vs_n high.
   function automatic int count_match(input int what, input int lo, input int hi);
      int n;
      n = 0;
      for (int c = lo; c <= hi && c < LINE; c++) begin
         case (what)
            0:       if (rgb_s[c] !== 8'h00) n++;
            1:       if (de_s[c] === 1'b1) n++;
            2:       if (hs_s[c] === 1'b0) n++;
            3:       if (vs_s[c] === 1'b0) n++;
            default: if (vs_s[c] === 1'b1) n++;
         endcase
      end
      return n;
   endfunction

   // Drives one source line of 'len' cycles and captures outputs.
   // rst_at >= 0 pulls rst_n low for cycles rst_at and rst_at+1.
   task automatic drive_line(input int mode, input bit vs, input int len, input int rst_at);
      int         k;
      logic [7:0] kb;
      for (int c = 0; c < len; c++) begin
         out_en      = (c % 2 == 0);
         pix_en      = (c % 4 == 0);
         src_hsync_n = !(c >= 2 && c < 66);
         src_vsync_n = vs;
         rst_n       = !(rst_at >= 0 && c >= rst_at && c < rst_at + 2);
         video_valid = 1'b0;
         {r_sig, g_sig, b_sig} = 8'hA5;
         if (c % 4 == 0 && c >= 4) begin
            k  = (c - 4) / 4;
            kb = k[7:0];
            video_valid = (k < 256) && !(mode == 1 && k >= 100 && k <= 109);
            {r_sig, g_sig, b_sig} = (mode == 2) ? ~kb : kb;
         end
         @(posedge clk);
         @(negedge clk);
         de_s[c]  = vga_de;
         rgb_s[c] = {vga_r, vga_g, vga_b};
         hs_s[c]  = vga_hs_n;
         vs_s[c]  = vga_vs_n;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      video_valid = 1'b0;
      {r_sig, g_sig, b_sig} = 8'hFF;
      src_hsync_n = 1'b1;
      src_vsync_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         out_en = (c % 2 == 0);
         pix_en = (c % 4 == 0);
         @(posedge clk);
         @(negedge clk);
      end
      checks++;
      if (vga_de !== 1'b0) begin
         errors++; $display("FAIL reset_de: got %b expected 0", vga_de);
      end
      checks++;
      if ({vga_r, vga_g, vga_b} !== 8'h00) begin
         errors++; $display("FAIL reset_rgb: got %h expected 00", {vga_r, vga_g, vga_b});
      end
      checks++;
      if (vga_hs_n !== 1'b1) begin
         errors++; $display("FAIL reset_hs_n: got %b expected 1", vga_hs_n);
      end
      checks++;
      if (vga_vs_n !== 1'b1) begin
         errors++; $display("FAIL reset_vs_n: got %b expected 1", vga_vs_n);
      end
   endtask

   task automatic test_priming();
      int n;
      // First line start: not yet primed.
      drive_line(0, 1'b1, LINE, -1);
      n = count_match(1, 0, LINE - 1);
      checks++;
      if (n !== 0) begin
         errors++; $display("FAIL unprimed_de: got %0d de cycles expected 0", n);
      end
      n = count_match(0, 0, LINE - 1);
      checks++;
      if (n !== 0) begin
         errors++; $display("FAIL unprimed_rgb: got %0d nonzero cycles expected 0", n);
      end
      // Second line start: primed, replays the ramp twice.
      drive_line(1, 1'b1, LINE, -1);
      n = count_match(1, 0, 767);
      checks++;
      if (n !== 512) begin
         errors++; $display("FAIL de_count_replay0: got %0d expected 512", n);
      end
      n = count_match(1, 768, LINE - 1);
      checks++;
      if (n !== 512) begin
         errors++; $display("FAIL de_count_replay1: got %0d expected 512", n);
      end
      n = scan_bad(1, 0, 1'b1);
      checks++;
      if (n !== 0) begin
         errors++; $display("FAIL de_window: %0d bad, cycle %0d got %h expected %h", n, bad_c, bad_act, bad_exp);
      end
      n = scan_bad(0, 0, 1'b1);
      checks++;
      if (n !== 0) begin
         errors++; $display("FAIL ramp_rgb: %0d bad, cycle %0d got %h expected %h", n, bad_c, bad_act, bad_exp);
      end
      n = scan_bad(2, 0, 1'b1);
      checks++;
      if (n !== 0) begin
         errors++; $display("FAIL hs_window: %0d bad, cycle %0d got %h expected %h", n, bad_c, bad_act, bad_exp);
      end
   endtask

   task automatic test_blanking();
      int n;
      drive_line(2, 1'b1, LINE, -1);
      n = scan_bad(0, 1, 1'b1);
      checks++;
      if (n !== 0) begin
         errors++; $display("FAIL blank_rgb: %0d bad, cycle %0d got %h expected %h", n, bad_c, bad_act, bad_exp);
      end
      checks++;
      if (rgb_s[4 + 2 * 163] !== 8'd99) begin
         errors++; $display("FAIL blank_edge_163: got %h expected 63", rgb_s[4 + 2 * 163]);
      end
      checks++;
      if (rgb_s[4 + 2 * 164] !== 8'h00) begin
         errors++; $display("FAIL blank_first_164: got %h expected 00", rgb_s[4 + 2 * 164]);
      end
      checks++;
      if (rgb_s[772 + 2 * 173] !== 8'h00) begin
         errors++; $display("FAIL blank_last_173_r1: got %h expected 00", rgb_s[772 + 2 * 173]);
      end
      checks++;
      if (rgb_s[772 + 2 * 174] !== 8'd110) begin
         errors++; $display("FAIL blank_edge_174_r1: got %h expected 6e", rgb_s[772 + 2 * 174]);
      end
   endtask

   task automatic test_vsync();
      int n;
      drive_line(0, 1'b0, LINE, -1);
      n = count_match(3, 4, LINE - 1);
      checks++;
      if (n !== LINE - 4) begin
         errors++; $display("FAIL vs_low_period: got %0d low cycles expected %0d", n, LINE - 4);
      end
      n = scan_bad(0, 2, 1'b1);
      checks++;
      if (n !== 0) begin
         errors++; $display("FAIL inv_rgb: %0d bad, cycle %0d got %h expected %h", n, bad_c, bad_act, bad_exp);
      end
      drive_line(0, 1'b1, LINE, -1);
      checks++;
      if (vs_s[3] !== 1'b0) begin
         errors++; $display("FAIL vs_latency_hold: got %b expected 0", vs_s[3]);
      end
      n = count_match(4, 4, LINE - 1);
      checks++;
      if (n !== LINE - 4) begin
         errors++; $display("FAIL vs_high_period: got %0d high cycles expected %0d", n, LINE - 4);
      end
      n = scan_bad(0, 0, 1'b1);
      checks++;
      if (n !== 0) begin
         errors++; $display("FAIL ramp_after_vs: %0d bad, cycle %0d got %h expected %h", n, bad_c, bad_act, bad_exp);
      end
   endtask

   task automatic test_mid_count();
      int n;
      // Short line: the next line start lands with hcnt=200 and out_en high.
      drive_line(0, 1'b1, 402, -1);
      drive_line(0, 1'b1, LINE, -1);
      n = scan_bad(2, 0, 1'b1);
      checks++;
      if (n !== 0) begin
         errors++; $display("FAIL relock_hs: %0d bad, cycle %0d got %h expected %h", n, bad_c, bad_act, bad_exp);
      end
      n = count_match(2, 0, 767);
      checks++;
      if (n !== 64) begin
         errors++; $display("FAIL relock_hs_width: got %0d low cycles expected 64", n);
      end
      checks++;
      if ({hs_s[643], hs_s[644]} !== 2'b10) begin
         errors++; $display("FAIL relock_hs_start: got %b expected 10", {hs_s[643], hs_s[644]});
      end
      n = scan_bad(1, 0, 1'b1);
      checks++;
      if (n !== 0) begin
         errors++; $display("FAIL relock_de: %0d bad, cycle %0d got %h expected %h", n, bad_c, bad_act, bad_exp);
      end
   endtask

   task automatic test_reset_mid_line();
      int n;
      // Reset lands with wr_ptr=120, during an active replay with vsync low.
      drive_line(0, 1'b0, LINE, 484);
      checks++;
      if ({de_s[483], vs_s[483], rgb_s[483]} !== {1'b1, 1'b0, 8'd175}) begin
         errors++; $display("FAIL pre_reset_state: got %b %b %h expected 1 0 af", de_s[483], vs_s[483], rgb_s[483]);
      end
      checks++;
      if ({de_s[484], hs_s[484], vs_s[484], rgb_s[484]} !== {1'b0, 1'b1, 1'b1, 8'h00}) begin
         errors++; $display("FAIL mid_reset_outputs: got %b %b %b %h expected 0 1 1 00", de_s[484], hs_s[484], vs_s[484], rgb_s[484]);
      end
      n = count_match(1, 484, LINE - 1);
      checks++;
      if (n !== 0) begin
         errors++; $display("FAIL post_reset_de: got %0d de cycles expected 0", n);
      end
      drive_line(0, 1'b1, LINE, -1);
      n = count_match(1, 0, LINE - 1) + count_match(0, 0, LINE - 1);
      checks++;
      if (n !== 0) begin
         errors++; $display("FAIL reprime_first_line: got %0d de/rgb cycles expected 0", n);
      end
      drive_line(0, 1'b1, LINE, -1);
      n = count_match(1, 0, LINE - 1);
      checks++;
      if (n !== 1024) begin
         errors++; $display("FAIL reprime_de_count: got %0d expected 1024", n);
      end
      n = scan_bad(0, 0, 1'b1);
      checks++;
      if (n !== 0) begin
         errors++; $display("FAIL reprime_rgb: %0d bad, cycle %0d got %h expected %h", n, bad_c, bad_act, bad_exp);
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      pix_en      = 1'b0;
      out_en      = 1'b0;
      video_valid = 1'b0;
      r_sig       = '0;
      g_sig       = '0;
      b_sig       = '0;
      src_hsync_n = 1'b1;
      src_vsync_n = 1'b1;
      test_reset();
      test_priming();
      test_blanking();
      test_vsync();
      test_mid_count();
      test_reset_mid_line();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
